// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master arbiter and helpers.
package spi_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      START,
      WAIT,
      HOLD,
      RELEASE
   } spi_state_t;

   // {ckp,cph} encodings
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: first set request after i_ptr, with wrap.
module spi_rr_picker #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_any,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx
);

   logic w_found;

   assign o_any = |i_req;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_found  = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int c = 0; c < N; c++) begin
            if (!w_found && i_req[c] && (c == (int'(i_ptr) + k) % N)) begin
               w_found     = 1'b1;
               o_onehot[c] = 1'b1;
               o_idx       = IW'(c);
            end
         end
      end
   end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one byte-level SPI engine between NREQ clients,
// with per-transaction chip select guard times and latched length/mode.
module spi_master_arbiter
   import spi_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LEN_W    = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*LEN_W-1:0]  req_len,
   input  logic [NREQ*2-1:0]      req_mode,
   input  logic [NREQ*DATA_W-1:0] tx_data,
   output logic [NREQ-1:0]        tx_ready,
   output logic [DATA_W-1:0]      rx_data,
   output logic [NREQ-1:0]        rx_valid,
   output logic [NREQ-1:0]        grant,
   output logic [NREQ-1:0]        done,
   output logic [NREQ-1:0]        cs_n,
   output logic                   eng_start,
   output logic [DATA_W-1:0]      eng_tx,
   output logic                   eng_ckp,
   output logic                   eng_cph,
   input  logic                   eng_busy,
   input  logic                   eng_done,
   input  logic [DATA_W-1:0]      eng_rx
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int GW = 16;

   spi_state_t        r_state;
   spi_state_t        w_next;
   logic [IW-1:0]     r_ptr;
   logic [IW-1:0]     r_idx;
   logic [LEN_W-1:0]  r_len;
   logic [1:0]        r_mode;
   logic [GW-1:0]     r_gcnt;
   logic [DATA_W-1:0] r_rx;
   logic [NREQ-1:0]   r_rxv;

   logic              w_any;
   logic [NREQ-1:0]   w_onehot;
   logic [IW-1:0]     w_pidx;
   logic [LEN_W-1:0]  w_plen;
   logic [1:0]        w_pmode;
   logic [DATA_W-1:0] w_txb;
   logic [NREQ-1:0]   w_sel;
   logic              w_active;

   spi_rr_picker #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_any    (w_any),
      .o_onehot (w_onehot),
      .o_idx    (w_pidx)
   );

   always_comb begin
      w_plen  = '0;
      w_pmode = '0;
      w_txb   = '0;
      for (int c = 0; c < NREQ; c++) begin
         if (w_pidx == IW'(c)) begin
            w_plen  = req_len[c*LEN_W +: LEN_W];
            w_pmode = req_mode[c*2 +: 2];
         end
         if (r_idx == IW'(c)) begin
            w_txb = tx_data[c*DATA_W +: DATA_W];
         end
      end
   end

   assign w_sel    = NREQ'(1) << r_idx;
   assign w_active = (r_state == SETUP) || (r_state == START) ||
                     (r_state == WAIT)  || (r_state == HOLD);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      eng_start = 1'b0;
      eng_tx    = '0;
      tx_ready  = '0;
      done      = '0;
      grant     = w_active ? w_sel : '0;
      cs_n      = w_active ? ~w_sel : '1;
      case (r_state)
         IDLE: begin
            if (w_any) w_next = SETUP;
         end
         SETUP: begin
            if (r_gcnt == GW'(CS_SETUP - 1)) begin
               w_next = (r_len == '0) ? HOLD : START;
            end
         end
         START: begin
            if (!eng_busy) begin
               eng_start = 1'b1;
               eng_tx    = w_txb;
               tx_ready  = w_sel;
               w_next    = WAIT;
            end
         end
         WAIT: begin
            if (eng_done) begin
               w_next = (r_len == LEN_W'(1)) ? HOLD : START;
            end
         end
         HOLD: begin
            if (r_gcnt == GW'(CS_HOLD - 1)) w_next = RELEASE;
         end
         RELEASE: begin
            done   = w_sel;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr  <= IW'(NREQ - 1);
         r_idx  <= '0;
         r_len  <= '0;
         r_mode <= '0;
         r_gcnt <= '0;
         r_rx   <= '0;
         r_rxv  <= '0;
      end else begin
         r_rxv <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_idx  <= w_pidx;
                  r_len  <= w_plen;
                  r_mode <= w_pmode;
                  r_gcnt <= '0;
               end
            end
            SETUP: begin
               r_gcnt <= (w_next == SETUP) ? r_gcnt + 1'b1 : '0;
            end
            WAIT: begin
               if (eng_done) begin
                  r_rx  <= eng_rx;
                  r_rxv <= w_sel;
                  if (r_len != '0) r_len <= r_len - 1'b1;
               end
            end
            HOLD: begin
               r_gcnt <= r_gcnt + 1'b1;
            end
            RELEASE: begin
               r_ptr <= r_idx;
            end
            default: ;
         endcase
      end
   end

   assign rx_data  = r_rx;
   assign rx_valid = r_rxv;
   assign eng_ckp  = r_mode[1];
   assign eng_cph  = r_mode[0];

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with an echoing engine model.
module tb_spi_master_arbiter;

   localparam int NREQ = 2;
   localparam int DW   = 8;
   localparam int LW   = 4;
   localparam int LAT  = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*LW-1:0] req_len;
   logic [NREQ*2-1:0] req_mode;
   logic [NREQ*DW-1:0] tx_data;
   logic [NREQ-1:0]   tx_ready;
   logic [DW-1:0]     rx_data;
   logic [NREQ-1:0]   rx_valid;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic [NREQ-1:0]   cs_n;
   logic              eng_start;
   logic [DW-1:0]     eng_tx;
   logic              eng_ckp;
   logic              eng_cph;
   logic              eng_busy;
   logic              eng_done;
   logic [DW-1:0]     eng_rx;

   spi_master_arbiter #(
      .NREQ(NREQ), .DATA_W(DW), .LEN_W(LW), .CS_SETUP(2), .CS_HOLD(2)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_len(req_len),
      .req_mode(req_mode), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .grant(grant), .done(done),
      .cs_n(cs_n), .eng_start(eng_start), .eng_tx(eng_tx),
      .eng_ckp(eng_ckp), .eng_cph(eng_cph), .eng_busy(eng_busy),
      .eng_done(eng_done), .eng_rx(eng_rx)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(int i, int n);
      logic [7:0] b;
      if (i == 0) begin
         case (n % 8)
            0: b = 8'h08;
            1: b = 8'h02;
            2: b = 8'h06;
            3: b = 8'h5A;
            4: b = 8'hC3;
            5: b = 8'h11;
            6: b = 8'h7E;
            default: b = 8'h90;
         endcase
      end else begin
         b = 8'hA0 ^ 8'(n % 16);
      end
      return b;
   endfunction

   // engine model: done LAT+1 cycles after start, echoes inverted byte
   logic       m_busy = 1'b0;
   int         m_cnt = 0;
   logic [7:0] m_byte = 8'h00;
   logic       busy_force;

   initial begin
      eng_done = 1'b0;
      eng_rx   = 8'h00;
   end

   always @(posedge clk) begin
      eng_done <= 1'b0;
      if (reset) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
         eng_rx <= 8'h00;
      end else if (eng_start) begin
         m_busy <= 1'b1;
         m_cnt  <= LAT;
         m_byte <= eng_tx;
      end else if (m_busy) begin
         if (m_cnt == 1) begin
            eng_done <= 1'b1;
            eng_rx   <= ~m_byte;
            m_busy   <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   assign eng_busy = m_busy | busy_force;

   int txp[NREQ] = '{0, 0};
   always @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (tx_ready[i]) txp[i] <= txp[i] + 1;
      end
   end
   assign tx_data = {pat(1, txp[1]), pat(0, txp[0])};

   // monitor
   logic [7:0]      starts[$];
   logic [7:0]      rxb[$];
   int              rxi[$];
   int              gq[$];
   int              donecnt[NREQ] = '{0, 0};
   int              cur[NREQ] = '{0, 0};
   int              lastlow[NREQ] = '{0, 0};
   int              overlap = 0;
   int              mode_err = 0;
   logic [1:0]      exp_mode = 2'b00;
   logic [NREQ-1:0] prev_grant = '0;

   always @(negedge clk) begin
      if (eng_start) starts.push_back(eng_tx);
      for (int i = 0; i < NREQ; i++) begin
         if (rx_valid[i]) begin
            rxb.push_back(rx_data);
            rxi.push_back(i);
         end
         if (done[i]) donecnt[i] = donecnt[i] + 1;
         if (!cs_n[i]) begin
            cur[i] = cur[i] + 1;
         end else if (cur[i] != 0) begin
            lastlow[i] = cur[i];
            cur[i] = 0;
         end
      end
      if (cs_n == 2'b00) overlap = overlap + 1;
      if (grant != 0 && {eng_ckp, eng_cph} != exp_mode) mode_err = mode_err + 1;
      if (grant != 0 && prev_grant == 0) gq.push_back(grant[1] ? 1 : 0);
      prev_grant = grant;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_done(int idx, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (done[idx]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      int         idx;
      int         len;
      logic [1:0] mode;
      int         exp_low;
   } row_t;

   row_t rows[4];

   initial begin
      bit         ok;
      int         bs, br, bd, bp, bg, d, bad, idx, len, na, nr;
      logic [7:0] eb;

      // cs low = CS_SETUP + len*(LAT+2) + CS_HOLD
      rows[0] = '{idx: 0, len: 3, mode: 2'b01, exp_low: 19};
      rows[1] = '{idx: 1, len: 0, mode: 2'b00, exp_low: 4};
      rows[2] = '{idx: 1, len: 2, mode: 2'b11, exp_low: 14};
      rows[3] = '{idx: 0, len: 1, mode: 2'b10, exp_low: 9};

      reset = 1'b1;
      req = '0;
      req_len = '0;
      req_mode = '0;
      busy_force = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_cs_n", cs_n, 2'b11);
      check("rst_start", {eng_start, tx_ready, rx_valid, done}, 0);
      check("rst_eng_tx", eng_tx, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_mode", {eng_ckp, eng_cph}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int r = 0; r < 4; r++) begin
         idx = rows[r].idx;
         len = rows[r].len;
         exp_mode = rows[r].mode;
         req_len[idx*LW +: LW] = LW'(len);
         req_mode[idx*2 +: 2] = rows[r].mode;
         bs = starts.size();
         br = rxb.size();
         bd = donecnt[idx];
         bp = txp[idx];
         @(posedge clk); #1;
         req[idx] = 1'b1;
         @(negedge clk);
         check("grant_lat0", grant, 0);
         @(negedge clk);
         check("grant_lat1", grant, 1 << idx);
         wait_done(idx, ok);
         check("done_seen", ok, 1);
         @(posedge clk); #1;
         req[idx] = 1'b0;
         repeat (3) @(negedge clk);
         na = starts.size() - bs;
         nr = rxb.size() - br;
         check("start_cnt", na, len);
         check("rx_cnt", nr, len);
         for (int k = 0; k < len && k < na && k < nr; k++) begin
            eb = pat(idx, bp + k);
            check("eng_tx", starts[bs+k], eb);
            eb = ~eb;
            check("rx_data", rxb[br+k], eb);
            check("rx_idx", rxi[br+k], idx);
         end
         check("cs_low", lastlow[idx], rows[r].exp_low);
         check("done_cnt", donecnt[idx] - bd, 1);
         check("mode", mode_err, 0);
      end

      // reset during second byte of a len=4 transfer
      exp_mode = 2'b11;
      req_len[3:0] = 4'd4;
      req_mode[1:0] = 2'b11;
      bs = starts.size();
      @(posedge clk); #1;
      req[0] = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (starts.size() - bs >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      check("second_byte", ok, 1);
      bd = donecnt[0];
      @(posedge clk); #1;
      reset = 1'b1;
      req = '0;
      @(posedge clk); #1;
      check("rstmid_cs_n", cs_n, 2'b11);
      check("rstmid_grant", grant, 0);
      check("rstmid_done", done, 0);
      check("rstmid_out", {eng_start, rx_valid, eng_ckp, eng_cph}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rstmid_no_done", donecnt[0] - bd, 0);

      // contention: both held for four transactions
      exp_mode = 2'b00;
      req_len = {4'd1, 4'd1};
      req_mode = '0;
      bg = gq.size();
      @(posedge clk); #1;
      req = 2'b11;
      d = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         d += $countones(done);
         if (d >= 4) break;
      end
      @(posedge clk); #1;
      req = 2'b00;
      repeat (5) @(negedge clk);
      check("rr_grants", gq.size() - bg, 4);
      for (int k = 0; k < 4 && bg + k < gq.size(); k++) begin
         check("rr_order", gq[bg+k], k % 2);
      end
      check("cs_overlap", overlap, 0);
      check("rr_mode", mode_err, 0);

      // engine busy at START
      busy_force = 1'b1;
      exp_mode = 2'b10;
      req_len[7:4] = 4'd1;
      req_mode[3:2] = 2'b10;
      bp = txp[1];
      br = rxb.size();
      @(posedge clk); #1;
      req[1] = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (!cs_n[1]) begin
            ok = 1'b1;
            break;
         end
      end
      check("busy_cs_low", ok, 1);
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (eng_start || cs_n[1]) bad++;
      end
      check("busy_hold", bad, 0);
      @(posedge clk); #1;
      busy_force = 1'b0;
      @(negedge clk);
      check("busy_start", eng_start, 1);
      eb = pat(1, bp);
      check("busy_tx", eng_tx, eb);
      wait_done(1, ok);
      check("busy_done", ok, 1);
      @(posedge clk); #1;
      req[1] = 1'b0;
      repeat (3) @(negedge clk);
      eb = ~pat(1, bp);
      if (rxb.size() > br) check("busy_rx", rxb[br], eb);
      else check("busy_rx_cnt", rxb.size() - br, 1);

      // request dropped after grant
      exp_mode = 2'b00;
      req_len[3:0] = 4'd2;
      req_mode[1:0] = 2'b00;
      bs = starts.size();
      br = rxb.size();
      bd = donecnt[0];
      @(posedge clk); #1;
      req[0] = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (grant[0]) begin
            ok = 1'b1;
            break;
         end
      end
      check("drop_grant", ok, 1);
      @(posedge clk); #1;
      req[0] = 1'b0;
      wait_done(0, ok);
      check("drop_done", ok, 1);
      repeat (3) @(negedge clk);
      check("drop_starts", starts.size() - bs, 2);
      check("drop_rx", rxb.size() - br, 2);
      check("drop_done_cnt", donecnt[0] - bd, 1);
      check("final_overlap", overlap, 0);
      check("final_mode", mode_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one byte-level SPI master engine between NREQ requesters using round-robin arbitration.
- Per granted transaction it:
  - latches the requester's byte count and SPI mode (ckp/cph);
  - drives that requester's chip select with programmable setup and hold guard times;
  - issues one engine start per byte and routes each received byte back to the requester.
- Sits between protocol clients (sensor readers, display writers) and the SPI master transmitter.

Parameters:
- NREQ, 2, number of requesters/slave selects (2..4)
- DATA_W, 8, byte width of the engine interface
- LEN_W, 4, width of per-request byte count
- CS_SETUP, 2, clk cycles cs_n is low before first eng_start
- CS_HOLD, 2, clk cycles after last eng_done before cs_n goes high

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous active-high reset
- req  in  NREQ  request level per requester; must hold until its done pulse
- req_len  in  NREQ*LEN_W  byte count per requester, slice i at [i*LEN_W +: LEN_W]
- req_mode  in  NREQ*2  {ckp,cph} per requester
- tx_data  in  NREQ*DATA_W  next byte to send per requester
- tx_ready  out  NREQ  1-cycle pulse: current tx_data byte consumed; requester presents next byte on following cycle
- rx_data  out  DATA_W  received byte (shared bus)
- rx_valid  out  NREQ  1-cycle pulse qualifying rx_data for requester i
- grant  out  NREQ  one-hot, high for whole transaction
- done  out  NREQ  1-cycle pulse at transaction end
- cs_n  out  NREQ  active-low slave selects, at most one low
- eng_start  out  1  1-cycle pulse to engine
- eng_tx  out  DATA_W  byte to engine, valid with eng_start
- eng_ckp, eng_cph  out  1 each  mode to engine, stable whole transaction
- eng_busy  in  1  engine busy
- eng_done  in  1  1-cycle pulse, byte complete
- eng_rx  in  DATA_W  received byte, valid with eng_done

Behaviour:
- Reset values: grant=0, cs_n all 1, tx_ready=0, rx_valid=0, done=0, eng_start=0, eng_tx=0, eng_ckp=0, eng_cph=0, rx_data=0. Round-robin pointer = NREQ-1, so req[0] has first priority. State=IDLE.
- FSM states: IDLE, SETUP, START, WAIT, HOLD, RELEASE.
- IDLE:
  - If any req is set, select the first set bit searching from pointer+1 with wrap.
  - Latch index, len and mode; set grant one-hot; go to SETUP. Grant appears the cycle after req is sampled.
- SETUP:
  - cs_n[idx]=0.
  - Count CS_SETUP cycles, then go to START. If the latched len==0, go to HOLD instead.
- START:
  - Only proceeds when eng_busy=0, otherwise waits.
  - eng_start=1 with eng_tx=tx_data[idx]; tx_ready[idx]=1 the same cycle; go to WAIT.
- WAIT:
  - On eng_done: rx_data<=eng_rx, rx_valid[idx] pulses the next cycle, remaining count is decremented.
  - If remaining count is now 0, go to HOLD; else go to START.
  - Minimum inter-byte gap is 1 cycle.
- HOLD: count CS_HOLD cycles with cs_n still low, then go to RELEASE.
- RELEASE:
  - cs_n all 1, grant=0, done[idx]=1, pointer<=idx; go to IDLE.
  - Therefore cs_n is high for at least 1 cycle between transactions.
- Byte count: counter is LEN_W wide; len=2^LEN_W-1 is the maximum. No wrap because decrement stops at 0.
- req deasserted mid-transaction: ignored; the transaction runs to completion.
- req_len/req_mode changes after grant: ignored (latched values used).
- eng_done outside WAIT: ignored.
- Simultaneous requests: round-robin order. A requester that just finished has lowest priority next.
- reset mid-transaction: all outputs return to reset values on the next edge, with no done pulse. The engine is expected to be reset by the same signal.

Decomposition:
- Shared package spi_pkg: state enum (IDLE..RELEASE), mode encoding constants for {ckp,cph} modes 0-3, and the default DATA_W.
- One sub-module, spi_rr_picker: combinational round-robin select from req and pointer, returning one-hot plus index. It is reusable by other bus arbiters.

Test Plan:
- Single request: req[0]=1, len=3, mode=2'b01, tx bytes 0x08,0x02,0x06 with the engine model echoing the inverted byte. Expect:
  - cs_n[0] low for 2+3*T+2 cycles;
  - exactly 3 eng_start pulses carrying 0x08,0x02,0x06;
  - rx_valid[0] pulses with 0xF7,0xFD,0xF9;
  - one done[0] pulse; eng_ckp=0, eng_cph=1 throughout.
- Contention: req[0] and req[1] asserted in the same cycle after reset, len=1 each. Expect:
  - grant order 0 then 1;
  - repeated with both held: order alternates 0,1,0,1;
  - cs_n never low on two lines at once.
- Zero length: req[1]=1, len=0. Expect no eng_start, cs_n[1] low for exactly CS_SETUP+CS_HOLD cycles, then done[1].
- Engine busy: eng_busy held 1 for 10 cycles at START. Expect eng_start delayed until the cycle after eng_busy falls, with cs_n held low throughout.
- Reset mid-transfer: reset=1 during the second byte of a len=4 transfer. Expect cs_n=all 1, grant=0 and no done on the next edge; after release, a fresh req[0] is granted first.
- Request drop: req[0] dropped after grant with len=2. Expect both bytes still transferred and done[0] pulsed.
